// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_ctrl
// Description : APB master sequencer for Memory-stage loads and stores that
//               decode to the peripheral region. Each access runs one complete
//               APB transfer (SETUP then ACCESS). The pipeline is stalled until
//               the result is ready. Misaligned accesses and transfers that
//               exceed the wait-state budget are reported on PerErr.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT    : number of ACCESS-phase wait cycles before the transfer is
//                abandoned with an error
//   CNT_W      : width of the wait counter; 2**CNT_W must exceed TIMEOUT
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   IsPerM     : Memory-stage address is in peripheral space
//   MemWriteM  : Memory-stage store
//   MemReadM   : Memory-stage load
//   MemSizeM   : 00 byte, 01 half, 10/11 word
//   ALUResultM : access address
//   WriteDataM : store data, right-aligned
//   StallPer   : stall request to the hazard unit
//   proc_rdata : registered APB read word, raw and unshifted
//   PerErr     : registered error flag for the completed access
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB : APB master outputs
//   PREADY, PRDATA, PSLVERR                     : APB slave responses
// ============================================================================
module apb_master_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IsPerM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [1:0]  MemSizeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallPer,
  output logic [31:0] proc_rdata,
  output logic        PerErr,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;

  logic             w_req;
  logic             w_misaligned;
  logic             w_timeout;
  logic [31:0]      w_wdata;
  logic [3:0]       w_strb;

  assign w_req = IsPerM & (MemWriteM | MemReadM);

  // Half accesses must be 2-byte aligned; word accesses (10 and 11) must be
  // 4-byte aligned. Byte accesses are always aligned.
  always_comb begin
    w_misaligned = 1'b0;
    case (MemSizeM)
      2'b01:   w_misaligned = ALUResultM[0];
      2'b10,
      2'b11:   w_misaligned = |ALUResultM[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // Sub-word store data is replicated on every lane so the slave can pick
  // the addressed lane using PSTRB alone. Reads never assert a strobe.
  always_comb begin
    w_wdata = WriteDataM;
    w_strb  = 4'b1111;
    case (MemSizeM)
      2'b00: begin
        w_wdata = {4{WriteDataM[7:0]}};
        w_strb  = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        w_wdata = {2{WriteDataM[15:0]}};
        w_strb  = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = WriteDataM;
        w_strb  = 4'b1111;
      end
    endcase
    if (!MemWriteM) begin
      w_strb = 4'b0000;
    end
  end

  // Abort only when the slave is still not ready on the cycle the counter
  // has reached the limit; a late PREADY on that cycle still completes.
  assign w_timeout = (r_cnt == C_TIMEOUT) & ~PREADY;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and bus control. PSEL/PENABLE are pure state decodes so an
  // asynchronous reset removes them at once, with no clock edge needed.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    PSEL         = 1'b0;
    PENABLE      = 1'b0;
    StallPer     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next = w_misaligned ? DONE : SETUP;
        end
      end
      SETUP: begin
        PSEL         = 1'b1;
        w_state_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || w_timeout) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // The instruction leaves M on the edge ending this cycle, so the
        // request still visible here is the one just serviced.
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Released in DONE so the instruction advances with its result valid.
    StallPer = w_req & (r_state != DONE);
  end

  // --------------------------------------------------------------------------
  // Transfer datapath: request latch, wait counter and result registers.
  // Address, data and strobes are loaded only in IDLE, which keeps them
  // stable from SETUP through the end of ACCESS.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      PWRITE     <= 1'b0;
      proc_rdata <= '0;
      PerErr     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_misaligned) begin
              // Rejected without touching the bus.
              PerErr     <= 1'b1;
              proc_rdata <= '0;
            end else begin
              PADDR  <= ALUResultM;
              PWRITE <= MemWriteM;
              PWDATA <= w_wdata;
              PSTRB  <= w_strb;
            end
          end
        end
        ACCESS: begin
          if (PREADY) begin
            // Stores leave the previous read word in place.
            if (!PWRITE) begin
              proc_rdata <= PRDATA;
            end
            PerErr <= PSLVERR;
          end else if (w_timeout) begin
            PerErr     <= 1'b1;
            proc_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_ctrl
// Description : Directed self-checking bench for apb_master_ctrl. Each scenario
//               task drives one Memory-stage access, plays the APB slave and
//               compares the observed behaviour with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_ctrl;

  logic        clk;
  logic        rst;
  logic        IsPerM;
  logic        MemWriteM;
  logic        MemReadM;
  logic [1:0]  MemSizeM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallPer;
  logic [31:0] proc_rdata;
  logic        PerErr;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int checks;
  int failures;

  // Observations gathered by run_xfer for the calling scenario.
  int          stall_n;
  int          psel_n;
  int          pen_n;
  bit          stable;
  bit          done_ok;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        d_bus;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_strb;
  logic        s_write;

  apb_master_ctrl #(
    .TIMEOUT (255),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .IsPerM     (IsPerM),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .MemSizeM   (MemSizeM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallPer   (StallPer),
    .proc_rdata (proc_rdata),
    .PerErr     (PerErr),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one access just after a rising edge and follow it to DONE.
  // The slave raises PREADY on ACCESS cycle number waits+1.
  task automatic run_xfer(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd,
                          input logic serr);
    @(posedge clk); #1;
    IsPerM = 1'b1; MemWriteM = wr; MemReadM = ~wr; MemSizeM = size;
    ALUResultM = addr; WriteDataM = wd;
    PREADY = 1'b0; PRDATA = rd; PSLVERR = serr;
    stall_n = 0; psel_n = 0; pen_n = 0; stable = 1'b1; done_ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (StallPer) begin
        stall_n++;
        if (PSEL) begin
          psel_n++;
          if (psel_n == 1) begin
            s_addr = PADDR; s_wdata = PWDATA; s_strb = PSTRB; s_write = PWRITE;
          end else if (PADDR !== s_addr || PWDATA !== s_wdata || PSTRB !== s_strb ||
                       PWRITE !== s_write) begin
            stable = 1'b0;
          end
        end
        if (PSEL && PENABLE) begin
          pen_n++;
          PREADY = (pen_n > waits);
        end
      end else begin
        d_rdata = proc_rdata; d_err = PerErr; d_bus = PSEL | PENABLE;
        done_ok = 1'b1;
        PREADY  = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle_bus(input int n);
    @(posedge clk); #1;
    IsPerM = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, proc_rdata, PerErr, StallPer} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h PSTRB=%b rdata=%h err=%b stall=%b, want all 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, proc_rdata, PerErr, StallPer);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_word_read;
    run_xfer(1'b0, 2'b10, 32'h4000_0004, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
    checks++; if (done_ok !== 1'b1) begin failures++; $display("FAIL wr_done: got %b want 1", done_ok); end
    checks++; if (stall_n !== 3) begin failures++; $display("FAIL wr_stall: got %0d want 3", stall_n); end
    checks++; if (psel_n !== 2) begin failures++; $display("FAIL wr_psel: got %0d want 2", psel_n); end
    checks++; if (pen_n !== 1) begin failures++; $display("FAIL wr_penable: got %0d want 1", pen_n); end
    checks++; if (d_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_rdata: got %h want cafef00d", d_rdata); end
    checks++; if (d_err !== 1'b0) begin failures++; $display("FAIL wr_err: got %b want 0", d_err); end
    checks++; if (s_addr !== 32'h4000_0004 || s_write !== 1'b0 || s_strb !== 4'b0000) begin
      failures++; $display("FAIL wr_bus: got addr=%h write=%b strb=%b want 40000004/0/0000", s_addr, s_write, s_strb);
    end
    checks++; if (d_bus !== 1'b0) begin failures++; $display("FAIL wr_done_bus: got %b want 0", d_bus); end
    idle_bus(1);
  endtask

  task automatic test_byte_store;
    run_xfer(1'b1, 2'b00, 32'h4000_0003, 32'h0000_00A5, 4, 32'h1111_1111, 1'b0);
    checks++; if (done_ok !== 1'b1) begin failures++; $display("FAIL bs_done: got %b want 1", done_ok); end
    checks++; if (stall_n !== 7) begin failures++; $display("FAIL bs_stall: got %0d want 7", stall_n); end
    checks++; if (pen_n !== 5) begin failures++; $display("FAIL bs_penable: got %0d want 5", pen_n); end
    checks++; if (s_strb !== 4'b1000) begin failures++; $display("FAIL bs_strb: got %b want 1000", s_strb); end
    checks++; if (s_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL bs_wdata: got %h want a5a5a5a5", s_wdata); end
    checks++; if (s_write !== 1'b1 || s_addr !== 32'h4000_0003) begin
      failures++; $display("FAIL bs_addr_write: got addr=%h write=%b want 40000003/1", s_addr, s_write);
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bs_stable: got %b want 1", stable); end
    // A store must not overwrite the previous read word.
    checks++; if (d_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL bs_rdata_kept: got %h want cafef00d", d_rdata); end
    checks++; if (d_err !== 1'b0) begin failures++; $display("FAIL bs_err: got %b want 0", d_err); end
    idle_bus(1);
  endtask

  task automatic test_misaligned;
    run_xfer(1'b0, 2'b01, 32'h4000_0001, 32'h0, 0, 32'h2222_2222, 1'b0);
    checks++; if (done_ok !== 1'b1) begin failures++; $display("FAIL mis_done: got %b want 1", done_ok); end
    checks++; if (stall_n !== 1) begin failures++; $display("FAIL mis_stall: got %0d want 1", stall_n); end
    checks++; if (psel_n !== 0) begin failures++; $display("FAIL mis_psel: got %0d want 0", psel_n); end
    checks++; if (d_err !== 1'b1) begin failures++; $display("FAIL mis_err: got %b want 1", d_err); end
    checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL mis_rdata: got %h want 0", d_rdata); end
    idle_bus(1);
  endtask

  task automatic test_non_peripheral;
    @(posedge clk); #1;
    IsPerM = 1'b0; MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; ALUResultM = 32'h4000_0004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (StallPer !== 1'b0 || PSEL !== 1'b0) begin
        failures++; $display("FAIL nonper_cycle%0d: got stall=%b psel=%b want 0/0", i, StallPer, PSEL);
      end
    end
    idle_bus(1);
  endtask

  task automatic test_timeout;
    // Load a nonzero read word first so the abort visibly clears it.
    run_xfer(1'b0, 2'b10, 32'h4000_0008, 32'h0, 0, 32'h5A5A_1234, 1'b0);
    checks++; if (d_rdata !== 32'h5A5A_1234 || d_err !== 1'b0) begin
      failures++; $display("FAIL to_pre_read: got rdata=%h err=%b want 5a5a1234/0", d_rdata, d_err);
    end
    idle_bus(1);
    // 255 counted wait cycles, then the abort cycle: 256 ACCESS cycles.
    run_xfer(1'b0, 2'b10, 32'h4000_000C, 32'h0, 1000, 32'hDEAD_BEEF, 1'b0);
    checks++; if (done_ok !== 1'b1) begin failures++; $display("FAIL to_done: got %b want 1", done_ok); end
    checks++; if (stall_n !== 258) begin failures++; $display("FAIL to_stall: got %0d want 258", stall_n); end
    checks++; if (pen_n !== 256) begin failures++; $display("FAIL to_access: got %0d want 256", pen_n); end
    checks++; if (d_err !== 1'b1 || d_rdata !== 32'h0) begin
      failures++; $display("FAIL to_result: got err=%b rdata=%h want 1/0", d_err, d_rdata);
    end
    checks++; if (d_bus !== 1'b0) begin failures++; $display("FAIL to_psel_drop: got %b want 0", d_bus); end
    idle_bus(1);
    checks++; if (PSEL !== 1'b0 || StallPer !== 1'b0) begin
      failures++; $display("FAIL to_idle: got psel=%b stall=%b want 0/0", PSEL, StallPer);
    end
  endtask

  task automatic test_back_to_back;
    int extra;
    run_xfer(1'b1, 2'b01, 32'h4000_0002, 32'h1234_BEEF, 0, 32'h0, 1'b0);
    checks++; if (done_ok !== 1'b1 || stall_n !== 3 || psel_n !== 2) begin
      failures++; $display("FAIL b2b_first: got done=%b stall=%0d psel=%0d want 1/3/2", done_ok, stall_n, psel_n);
    end
    checks++; if (s_strb !== 4'b1100 || s_wdata !== 32'hBEEF_BEEF) begin
      failures++; $display("FAIL b2b_half_lanes: got strb=%b wdata=%h want 1100/beefbeef", s_strb, s_wdata);
    end
    checks++; if (d_err !== 1'b0) begin failures++; $display("FAIL b2b_err1: got %b want 0", d_err); end
    // Second store follows straight after DONE; size 11 behaves as a word.
    run_xfer(1'b1, 2'b11, 32'h4000_0008, 32'h8765_4321, 0, 32'h0, 1'b1);
    checks++; if (done_ok !== 1'b1 || stall_n !== 3 || psel_n !== 2) begin
      failures++; $display("FAIL b2b_second: got done=%b stall=%0d psel=%0d want 1/3/2", done_ok, stall_n, psel_n);
    end
    checks++; if (s_strb !== 4'b1111 || s_wdata !== 32'h8765_4321 || s_addr !== 32'h4000_0008) begin
      failures++; $display("FAIL b2b_word_lanes: got strb=%b wdata=%h addr=%h want 1111/87654321/40000008", s_strb, s_wdata, s_addr);
    end
    checks++; if (d_err !== 1'b1) begin failures++; $display("FAIL b2b_err2: got %b want 1", d_err); end
    extra = 0;
    @(posedge clk); #1;
    IsPerM = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0; PSLVERR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (PSEL) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_no_dup: got %0d psel cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    bit in_access;
    in_access = 1'b0;
    @(posedge clk); #1;
    IsPerM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10;
    ALUResultM = 32'h4000_0010; PREADY = 1'b0; PRDATA = 32'h3333_3333;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (PENABLE) begin in_access = 1'b1; break; end
    end
    checks++; if (in_access !== 1'b1) begin failures++; $display("FAIL rm_reach_access: got %b want 1", in_access); end
    #2; rst = 1'b0; #1;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      failures++; $display("FAIL rm_async_drop: got psel=%b penable=%b want 0/0", PSEL, PENABLE);
    end
    IsPerM = 1'b0; MemReadM = 1'b0;
    @(posedge clk); @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, proc_rdata, PerErr, StallPer} !== '0) begin
      failures++;
      $display("FAIL rm_outputs: got PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h PSTRB=%b rdata=%h err=%b, want all 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, proc_rdata, PerErr);
    end
    // A fresh access with the normal 3-cycle latency shows the FSM is in IDLE.
    run_xfer(1'b0, 2'b10, 32'h4000_0014, 32'h0, 0, 32'h1122_3344, 1'b0);
    checks++; if (done_ok !== 1'b1 || stall_n !== 3 || d_rdata !== 32'h1122_3344) begin
      failures++; $display("FAIL rm_after: got done=%b stall=%0d rdata=%h want 1/3/11223344", done_ok, stall_n, d_rdata);
    end
    idle_bus(1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    IsPerM = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0; MemSizeM = 2'b00;
    ALUResultM = '0; WriteDataM = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    test_reset();
    test_word_read();
    test_byte_store();
    test_misaligned();
    test_non_peripheral();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
